// File: rtl/j1_intc_if.sv
// Bus bundle between the j1 core and j1_intc: interrupt sources, request/ack
// handshake and the four-register control port.
interface j1_intc_if #(
  parameter int unsigned NCH = 8
);
  logic [NCH-1:0] irq_in;
  logic           int_req;
  logic [15:0]    int_insn;
  logic           int_ack;
  logic [1:0]     reg_addr;
  logic           reg_wr;
  logic           reg_rd;
  logic [15:0]    reg_wdata;
  logic [15:0]    reg_rdata;

  modport master (
    output irq_in, int_ack, reg_addr, reg_wr, reg_rd, reg_wdata,
    input  int_req, int_insn, reg_rdata
  );

  modport slave (
    input  irq_in, int_ack, reg_addr, reg_wr, reg_rd, reg_wdata,
    output int_req, int_insn, reg_rdata
  );
endinterface

// File: rtl/j1_intc.sv
// Parametrised interrupt controller for the j1 core: enable/mode/pending/in-service
// state, priority arbitration and a registered call instruction. Define
// INTC_NESTING_EN to let higher-priority sources preempt a running handler.
module j1_intc #(
  parameter int unsigned NCH      = 8,
  parameter logic [12:0] VEC_BASE = 13'h1DF8
) (
  input  logic      clk,
  input  logic      reset,
  j1_intc_if.slave  bus
);
  localparam int unsigned IDW = (NCH > 1) ? $clog2(NCH) : 1;
  typedef logic [NCH-1:0] vec_t;

  vec_t           irq_prev_q;
  vec_t           enable_q, enable_d;
  vec_t           mode_q, mode_d;
  vec_t           pend_q, pend_d;
  vec_t           insvc_q, insvc_d;
  logic           req_q, req_d;
  logic [15:0]    insn_q, insn_d;
  logic [IDW-1:0] id_q, id_d;
  logic [15:0]    rdata_q, rdata_d;

  vec_t rise, clr, vis, elig, cand, pend_view, wd;
  logic ack;

  function automatic logic [IDW-1:0] top_idx(input vec_t v);
    logic [IDW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NCH; i++)
      if (v[i]) r = IDW'(i);
    return r;
  endfunction

  always_comb begin
    enable_d  = enable_q;
    mode_d    = mode_q;
    insvc_d   = insvc_q;
    rdata_d   = rdata_q;
    wd        = bus.reg_wdata[NCH-1:0];
    ack       = bus.int_ack & req_q;
    rise      = bus.irq_in & ~irq_prev_q & mode_q;
    pend_view = (pend_q & mode_q) | (bus.irq_in & ~mode_q);

    clr = '0;
    if (bus.reg_wr && bus.reg_addr == 2'd2) clr = wd & mode_q;
    if (ack) clr[id_q] = mode_q[id_q];
    pend_d = ((pend_q & ~clr) | rise) & mode_q;

    if (bus.reg_wr && bus.reg_addr == 2'd0) enable_d = wd;
    if (bus.reg_wr && bus.reg_addr == 2'd1) mode_d   = wd;

    // EOI retires the highest bit present before this cycle's ack is recorded
    if (bus.reg_wr && bus.reg_addr == 2'd3 && |insvc_q) insvc_d[top_idx(insvc_q)] = 1'b0;
    if (ack) insvc_d[id_q] = 1'b1;

    // A same-cycle edge keeps a just-cleared edge request visible
    vis = ((pend_q & (~clr | rise)) & mode_q) | (bus.irq_in & ~mode_q);

`ifdef INTC_NESTING_EN
    for (int unsigned i = 0; i < NCH; i++)
      elig[i] = ~|insvc_d || (IDW'(i) > top_idx(insvc_d));
`else
    elig = (|insvc_d) ? '0 : '1;
`endif

    cand   = vis & enable_d & elig;
    id_d   = top_idx(cand);
    req_d  = |cand;
    insn_d = {3'b010, VEC_BASE + 13'(id_d)};

    if (bus.reg_rd) begin
      case (bus.reg_addr)
        2'd0:    rdata_d = 16'(enable_q);
        2'd1:    rdata_d = 16'(mode_q);
        2'd2:    rdata_d = 16'(pend_view);
        default: rdata_d = 16'(insvc_q);
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_prev_q <= '0;
      enable_q   <= '0;
      mode_q     <= '0;
      pend_q     <= '0;
      insvc_q    <= '0;
      req_q      <= 1'b0;
      insn_q     <= '0;
      id_q       <= '0;
      rdata_q    <= '0;
    end else begin
      irq_prev_q <= bus.irq_in;
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      pend_q     <= pend_d;
      insvc_q    <= insvc_d;
      req_q      <= req_d;
      insn_q     <= insn_d;
      id_q       <= id_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.int_req   = req_q;
  assign bus.int_insn  = insn_q;
  assign bus.reg_rdata = rdata_q;
endmodule

// File: tb/tb_j1_intc.sv
// Self-checking bench for j1_intc: directed vector table, hand sequences for
// nesting/EOI/reset corners, and randomized traffic against a reference model.
module tb_j1_intc;
  localparam int unsigned NCH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  j1_intc_if #(.NCH(NCH)) bus ();
  j1_intc #(.NCH(NCH), .VEC_BASE(13'h1DF8)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0]  irq;
    logic        ack;
    logic [1:0]  addr;
    logic        wr;
    logic        rd;
    logic [15:0] wd;
    logic        ereq;
    logic [15:0] einsn;
    logic        crd;
    logic [15:0] erd;
  } vec_s;

  vec_s tbl[$];

  // Reference model state
  bit          use_model = 1'b0;
  logic [7:0]  m_en, m_mode, m_pend, m_isv, m_prev;
  logic        m_req;
  int          m_id;
  logic [15:0] m_insn, m_rd;

  function automatic int highest(input logic [7:0] v);
    int h = -1;
    for (int i = 0; i < 8; i++) if (v[i]) h = i;
    return h;
  endfunction

  function automatic vec_s mk(input logic [7:0] irq, input logic ack, input logic [1:0] addr,
                              input logic wr, input logic rd, input logic [15:0] wd,
                              input logic ereq, input logic [15:0] einsn,
                              input logic crd, input logic [15:0] erd);
    vec_s v;
    v.irq = irq; v.ack = ack; v.addr = addr; v.wr = wr; v.rd = rd; v.wd = wd;
    v.ereq = ereq; v.einsn = einsn; v.crd = crd; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_en = '0; m_mode = '0; m_pend = '0; m_isv = '0; m_prev = '0;
    m_req = 1'b0; m_id = 0; m_insn = '0; m_rd = '0;
  endtask

  task automatic model_step(input logic [7:0] irq, input logic ack, input logic [1:0] addr,
                            input logic wr, input logic rd, input logic [15:0] wd);
    logic [7:0] nen, nmode, nisv, npend, cand, pview;
    bit acked, edge_new, cleared, visible, elig;
    int h;
    nen = m_en; nmode = m_mode; nisv = m_isv; npend = '0; cand = '0;
    acked = ack && m_req;
    for (int i = 0; i < 8; i++) pview[i] = m_mode[i] ? m_pend[i] : irq[i];
    if (rd) begin
      case (addr)
        2'd0: m_rd = {8'h00, m_en};
        2'd1: m_rd = {8'h00, m_mode};
        2'd2: m_rd = {8'h00, pview};
        default: m_rd = {8'h00, m_isv};
      endcase
    end
    h = highest(m_isv);
    if (wr && addr == 2'd3 && h >= 0) nisv[h] = 1'b0;
    if (acked) nisv[m_id] = 1'b1;
    if (wr && addr == 2'd0) nen = wd[7:0];
    if (wr && addr == 2'd1) nmode = wd[7:0];
    for (int i = 0; i < 8; i++) begin
      edge_new = m_mode[i] && irq[i] && !m_prev[i];
      cleared  = m_mode[i] && ((acked && m_id == i) || (wr && addr == 2'd2 && wd[i]));
      npend[i] = m_mode[i] && (edge_new || (m_pend[i] && !cleared));
      visible  = m_mode[i] ? (m_pend[i] && (!cleared || edge_new)) : irq[i];
`ifdef INTC_NESTING_EN
      elig = i > highest(nisv);
`else
      elig = (nisv == 8'h00);
`endif
      cand[i] = visible && nen[i] && elig;
    end
    m_req  = (cand != 8'h00);
    m_id   = (highest(cand) < 0) ? 0 : highest(cand);
    m_insn = {3'b010, 13'h1DF8 + 13'(m_id)};
    m_en = nen; m_mode = nmode; m_isv = nisv; m_pend = npend; m_prev = irq;
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic cyc(input logic [7:0] irq, input logic ack, input logic [1:0] addr,
                     input logic wr, input logic rd, input logic [15:0] wd);
    bus.irq_in = irq; bus.int_ack = ack; bus.reg_addr = addr;
    bus.reg_wr = wr; bus.reg_rd = rd; bus.reg_wdata = wd;
    if (use_model) model_step(irq, ack, addr, wr, rd, wd);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.irq_in = '0; bus.int_ack = 1'b0; bus.reg_addr = '0;
    bus.reg_wr = 1'b0; bus.reg_rd = 1'b0; bus.reg_wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    bus.irq_in = '0; bus.int_ack = 1'b0; bus.reg_addr = '0;
    bus.reg_wr = 1'b0; bus.reg_rd = 1'b0; bus.reg_wdata = '0;
    reset = 1'b1;
    #1;
    chk("async_reset_req", {15'h0, bus.int_req}, 16'h0000);
    do_reset();
    chk("reset_req", {15'h0, bus.int_req}, 16'h0000);
    chk("reset_insn", bus.int_insn, 16'h0000);
    chk("reset_rdata", bus.reg_rdata, 16'h0000);

    //            irq   ack addr wr rd  wd        ereq einsn     crd erd
    tbl.push_back(mk(8'h00, 0, 2'd0, 1, 0, 16'h00FF, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 0, 2'd1, 1, 0, 16'h00FF, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(8'h08, 0, 2'd0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 0, 2'd0, 0, 0, 16'h0000, 1, 16'h5DFB, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 1, 2'd0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 0, 2'd3, 0, 1, 16'h0000, 0, 16'h0000, 1, 16'h0008));
    tbl.push_back(mk(8'h00, 0, 2'd2, 0, 1, 16'h0000, 0, 16'h0000, 1, 16'h0000));
    tbl.push_back(mk(8'h00, 0, 2'd3, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 0, 2'd3, 0, 1, 16'h0000, 0, 16'h0000, 1, 16'h0000));
    tbl.push_back(mk(8'h42, 0, 2'd0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 0, 2'd0, 0, 0, 16'h0000, 1, 16'h5DFE, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 1, 2'd0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 0, 2'd3, 1, 0, 16'h0000, 1, 16'h5DF9, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 1, 2'd0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 0, 2'd3, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 0, 2'd3, 0, 1, 16'h0000, 0, 16'h0000, 1, 16'h0000));
    tbl.push_back(mk(8'h00, 0, 2'd0, 1, 0, 16'h00EF, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(8'h10, 0, 2'd0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 0, 2'd2, 0, 1, 16'h0000, 0, 16'h0000, 1, 16'h0010));
    tbl.push_back(mk(8'h00, 0, 2'd0, 1, 0, 16'h00FF, 1, 16'h5DFC, 0, 16'h0000));
    tbl.push_back(mk(8'h10, 0, 2'd2, 1, 0, 16'h0010, 1, 16'h5DFC, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 0, 2'd2, 0, 1, 16'h0000, 1, 16'h5DFC, 1, 16'h0010));
    tbl.push_back(mk(8'h00, 1, 2'd0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 0, 2'd3, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 0, 2'd2, 0, 1, 16'h0000, 0, 16'h0000, 1, 16'h0000));
    tbl.push_back(mk(8'h00, 0, 2'd1, 1, 0, 16'h00FE, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(8'h01, 0, 2'd0, 0, 0, 16'h0000, 1, 16'h5DF8, 0, 16'h0000));
    tbl.push_back(mk(8'h01, 1, 2'd0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(8'h01, 0, 2'd0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(8'h01, 0, 2'd3, 1, 0, 16'h0000, 1, 16'h5DF8, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 1, 2'd0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 0, 2'd3, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 0, 2'd3, 0, 1, 16'h0000, 0, 16'h0000, 1, 16'h0000));
    tbl.push_back(mk(8'h00, 0, 2'd1, 1, 0, 16'h00FF, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(8'h00, 1, 2'd3, 0, 1, 16'h0000, 0, 16'h0000, 1, 16'h0000));

    foreach (tbl[i]) begin
      cyc(tbl[i].irq, tbl[i].ack, tbl[i].addr, tbl[i].wr, tbl[i].rd, tbl[i].wd);
      chk($sformatf("vec%0d_req", i), {15'h0, bus.int_req}, {15'h0, tbl[i].ereq});
      if (tbl[i].ereq) chk($sformatf("vec%0d_insn", i), bus.int_insn, tbl[i].einsn);
      if (tbl[i].crd)  chk($sformatf("vec%0d_rdata", i), bus.reg_rdata, tbl[i].erd);
    end

    // Preemption and EOI coinciding with ack
    cyc(8'h04, 0, 2'd0, 0, 0, 16'h0);
    cyc(8'h00, 0, 2'd0, 0, 0, 16'h0);
    chk("ch2_req", bus.int_insn & {16{bus.int_req}}, 16'h5DFA);
    cyc(8'h00, 1, 2'd0, 0, 0, 16'h0);
    chk("ch2_ack_req", {15'h0, bus.int_req}, 16'h0000);
    cyc(8'h20, 0, 2'd0, 0, 0, 16'h0);
    cyc(8'h02, 0, 2'd0, 0, 0, 16'h0);
`ifdef INTC_NESTING_EN
    chk("nest_ch5_insn", bus.int_insn & {16{bus.int_req}}, 16'h5DFD);
    cyc(8'h00, 1, 2'd3, 1, 0, 16'h0);
    chk("nest_ch1_blocked", {15'h0, bus.int_req}, 16'h0000);
    cyc(8'h00, 0, 2'd3, 0, 1, 16'h0);
    chk("eoi_ack_insvc", bus.reg_rdata, 16'h0020);
    chk("nest_ch1_still_pending", {15'h0, bus.int_req}, 16'h0000);
    cyc(8'h00, 0, 2'd3, 1, 0, 16'h0);
`else
    chk("nonest_ch5_waits", {15'h0, bus.int_req}, 16'h0000);
    cyc(8'h00, 0, 2'd2, 0, 1, 16'h0);
    chk("nonest_pending", bus.reg_rdata, 16'h0022);
    chk("nonest_still_waits", {15'h0, bus.int_req}, 16'h0000);
    cyc(8'h00, 0, 2'd3, 1, 0, 16'h0);
    chk("nonest_ch5_insn", bus.int_insn & {16{bus.int_req}}, 16'h5DFD);
    cyc(8'h00, 1, 2'd3, 1, 0, 16'h0);
    cyc(8'h00, 0, 2'd3, 0, 1, 16'h0);
    chk("eoi_ack_insvc", bus.reg_rdata, 16'h0020);
    chk("nonest_ch1_blocked", {15'h0, bus.int_req}, 16'h0000);
    cyc(8'h00, 0, 2'd3, 1, 0, 16'h0);
`endif
    chk("ch1_after_eois", bus.int_insn & {16{bus.int_req}}, 16'h5DF9);

    // Reset in the middle of a handler with a request outstanding
    cyc(8'h00, 1, 2'd0, 0, 0, 16'h0);
    cyc(8'h00, 0, 2'd3, 0, 1, 16'h0);
    chk("pre_reset_insvc", bus.reg_rdata, 16'h0002);
`ifdef INTC_NESTING_EN
    cyc(8'h08, 0, 2'd0, 0, 0, 16'h0);
    idle();
    chk("pre_reset_req", {15'h0, bus.int_req}, 16'h0001);
`else
    cyc(8'h08, 0, 2'd0, 0, 0, 16'h0);
    idle();
`endif
    #2 reset = 1'b1;
    #1;
    chk("midreset_req", {15'h0, bus.int_req}, 16'h0000);
    chk("midreset_insn", bus.int_insn, 16'h0000);
    chk("midreset_rdata", bus.reg_rdata, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      cyc(8'h00, 0, 2'(a), 0, 1, 16'h0);
      chk($sformatf("post_reset_reg%0d", a), bus.reg_rdata, 16'h0000);
    end
    chk("post_reset_req", {15'h0, bus.int_req}, 16'h0000);

    // Randomized traffic against the reference model
    do_reset();
    use_model = 1'b1;
    cyc(8'h00, 0, 2'd0, 1, 0, 16'h00FF);
    for (int n = 0; n < 3000; n++) begin
      logic [7:0]  irq;
      logic        ack, wr, rd;
      logic [1:0]  addr;
      logic [15:0] wd;
      irq  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : m_prev;
      ack  = m_req ? 1'($urandom) : ($urandom_range(0, 7) == 0);
      wr   = ($urandom_range(0, 5) == 0);
      rd   = 1'($urandom);
      addr = 2'($urandom);
      if (wr && addr < 2'd2 && $urandom_range(0, 3) != 0) addr = 2'd3;
      wd   = 16'($urandom);
      cyc(irq, ack, addr, wr, rd, wd);
      chk($sformatf("rnd%0d_req", n), {15'h0, bus.int_req}, {15'h0, m_req});
      chk($sformatf("rnd%0d_insn", n), bus.int_insn, m_insn);
      chk($sformatf("rnd%0d_rdata", n), bus.reg_rdata, m_rd);
    end
    use_model = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
